// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// Latency: result valid 4/COLS_PER_CYCLE edges after accept; one block every 4/COLS_PER_CYCLE+1 cycles.
// Backpressure: result held in DONE until i_ready; o_ready follows i_ready only in DONE.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_block,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_block,
    output logic         o_busy
);

    // Only widths that divide the four columns evenly are meaningful.
    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Column step as a 3-bit value so the carry out marks the final column group.
    localparam logic [2:0] COLS_STEP = 3'(COLS_PER_CYCLE);

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
    endfunction

    // InvMixColumns of one word; b0 is the most significant byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] b  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            b[i]  = w[31-8*i -: 8];
            x2[i] = gf_xtime(b[i]);
            x4[i] = gf_xtime(x2[i]);
            x8[i] = gf_xtime(x4[i]);
            m9[i] = x8[i] ^ b[i];
            mb[i] = x8[i] ^ x2[i] ^ b[i];
            md[i] = x8[i] ^ x4[i] ^ b[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    state_t         state_q,   state_d;
    logic [1:0]     col_q,     col_d;
    logic [127:0]   work_q,    work_d;
    logic           o_valid_q, o_valid_d;
    logic [127:0]   o_block_q, o_block_d;
    logic           busy_q,    busy_d;

    logic [127:0]   calc_work;
    logic [2:0]     col_sum;
    logic           accept;

    // Ready in IDLE, or in DONE when the result is being taken this cycle; never during reset.
    assign o_ready = !i_rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && i_ready));
    assign accept  = i_valid && o_ready;

    assign o_valid = o_valid_q;
    assign o_block = o_block_q;
    assign o_busy  = busy_q;

    // Transform the current column group in place; col_q is always a multiple of the step.
    always_comb begin
        calc_work = work_q;
        col_sum   = {1'b0, col_q} + COLS_STEP;
        for (int c = 0; c < COLS_PER_CYCLE; c++) begin
            calc_work[(3 - int'(col_q) - c)*32 +: 32] =
                inv_mix_col(work_q[(3 - int'(col_q) - c)*32 +: 32]);
        end
    end

    // Next-state and registered-output logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        work_d    = work_q;
        o_valid_d = o_valid_q;
        o_block_d = o_block_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    work_d  = i_block;
                    col_d   = 2'd0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                work_d = calc_work;
                col_d  = col_sum[1:0];
                // Carry out means column 3 was just processed.
                if (col_sum[2]) begin
                    o_block_d = calc_work;
                    o_valid_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    o_valid_d = 1'b0;
                    if (accept) begin
                        work_d  = i_block;
                        col_d   = 2'd0;
                        state_d = S_CALC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                o_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == S_CALC);
    end

    // State registers with synchronous reset; reset discards any in-flight block.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            col_q     <= 2'd0;
            work_q    <= '0;
            o_valid_q <= 1'b0;
            o_block_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            work_q    <= work_d;
            o_valid_q <= o_valid_d;
            o_block_q <= o_block_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed and randomised checks of inv_mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4.
// Inputs are driven at the falling edge; outputs are sampled at or just after it.
// Expected values are hand-computed vectors or an independent GF(2^8) reference.
module tb_inv_mix_columns_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst  [3];
    logic         ivld [3];
    logic         ordy [3];
    logic [127:0] iblk [3];
    logic         ovld [3];
    logic         irdy [3];
    logic [127:0] oblk [3];
    logic         busy [3];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'h4d7ebdf8_d5d5d7d6_8e4da1bc_01010101;
    localparam logic [127:0] E2 = 128'h2d26314c_d4d4d4d5_db135345_01010101;

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
        .i_clk(clk), .i_rst(rst[0]), .i_valid(ivld[0]), .o_ready(ordy[0]), .i_block(iblk[0]),
        .o_valid(ovld[0]), .i_ready(irdy[0]), .o_block(oblk[0]), .o_busy(busy[0]));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
        .i_clk(clk), .i_rst(rst[1]), .i_valid(ivld[1]), .o_ready(ordy[1]), .i_block(iblk[1]),
        .o_valid(ovld[1]), .i_ready(irdy[1]), .o_block(oblk[1]), .o_busy(busy[1]));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
        .i_clk(clk), .i_rst(rst[2]), .i_valid(ivld[2]), .o_ready(ordy[2]), .i_block(iblk[2]),
        .o_valid(ovld[2]), .i_ready(irdy[2]), .o_block(oblk[2]), .o_busy(busy[2]));

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Shift-and-add GF(2^8) multiply, independent of the xtime-chain structure.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Circulant matrix product per column; coef holds the first matrix row.
    function automatic logic [127:0] mat_ref(input logic [127:0] blk, input logic [31:0] coef);
        logic [127:0] r;
        logic [7:0]   acc;
        r = '0;
        for (int w = 0; w < 4; w++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int c = 0; c < 4; c++)
                    acc = acc ^ gmul(coef[31 - 8*((c - row) & 3) -: 8], blk[127 - 32*w - 8*c -: 8]);
                r[127 - 32*w - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Wait for the ready handshake, then drop valid after the accept edge.
    task automatic send(input int k, input logic [127:0] b);
        int n;
        n = 0;
        ivld[k] = 1'b1;
        iblk[k] = b;
        #1;
        while (!ordy[k] && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq($sformatf("send_ready_c%0d", k), 128'(ordy[k]), 128'd1);
        @(negedge clk);
        ivld[k] = 1'b0;
    endtask

    // Called at the falling edge right after the accept edge; counts edges to o_valid.
    task automatic wait_result(input int k, input logic [127:0] exp, input int exp_lat, input string tag);
        int lat;
        lat = 0;
        while (!ovld[k] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check_eq({tag, "_blk"}, oblk[k], exp);
        irdy[k] = 1'b1;
        @(negedge clk);
        irdy[k] = 1'b0;
        check_eq({tag, "_drop"}, 128'(ovld[k]), 128'd0);
    endtask

    task automatic rand_run(input int k, input int nblk);
        logic [127:0] q_in [$];
        logic [127:0] cur, inb;
        logic         pending;
        int           sent, got, cyc;
        sent = 0; got = 0; cyc = 0; pending = 1'b0; cur = '0;
        while (got < nblk && cyc < 40*nblk) begin
            if (!pending && sent < nblk && $urandom_range(0, 3) != 0) begin
                pending = 1'b1;
                cur = {$urandom, $urandom, $urandom, $urandom};
            end
            ivld[k] = pending;
            iblk[k] = pending ? cur : {$urandom, $urandom, $urandom, $urandom};
            irdy[k] = ($urandom_range(0, 3) != 0);
            #1;
            if (ovld[k] && irdy[k]) begin
                if (q_in.size() == 0) begin
                    check_eq($sformatf("rand_spurious_c%0d", k), 128'(q_in.size()), 128'd1);
                end else begin
                    inb = q_in.pop_front();
                    check_eq($sformatf("rand_ref_c%0d", k), oblk[k], mat_ref(inb, 32'h0e0b0d09));
                    check_eq($sformatf("rand_rt_c%0d", k), mat_ref(oblk[k], 32'h02030101), inb);
                end
                got++;
            end
            if (pending && ordy[k]) begin
                q_in.push_back(cur);
                pending = 1'b0;
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        ivld[k] = 1'b0;
        irdy[k] = 1'b0;
        check_eq($sformatf("rand_count_c%0d", k), 128'(got), 128'(nblk));
    endtask

    initial begin
        int t, ta, tb;
        logic seen;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; ivld[k] = 1'b0; irdy[k] = 1'b0; iblk[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst_vld_c%0d", k),  128'(ovld[k]), 128'd0);
            check_eq($sformatf("rst_blk_c%0d", k),  oblk[k], 128'd0);
            check_eq($sformatf("rst_busy_c%0d", k), 128'(busy[k]), 128'd0);
            check_eq($sformatf("rst_rdy_c%0d", k),  128'(ordy[k]), 128'd0);
            rst[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 3; k++)
            check_eq($sformatf("post_rst_rdy_c%0d", k), 128'(ordy[k]), 128'd1);
        @(negedge clk);

        // Single-column vectors
        send(0, V1);
        check_eq("t1_busy", 128'(busy[0]), 128'd1);
        wait_result(0, E1, 4, "t1");

        // Same block at every width; latency 4, 2, 1
        for (int k = 0; k < 3; k++) begin
            send(k, V2);
            wait_result(k, E2, 4 >> k, $sformatf("t2_c%0d", k));
        end

        // Back-pressure: result held while inputs churn
        send(0, V1);
        t = 0;
        while (!ovld[0] && t < 50) begin @(negedge clk); t++; end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ivld[0] = i[0];
            iblk[0] = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check_eq("bp_blk", oblk[0], E1);
            check_eq("bp_rdy", 128'(ordy[0]), 128'd0);
            check_eq("bp_vld", 128'(ovld[0]), 128'd1);
            @(negedge clk);
        end
        ivld[0] = 1'b0;
        irdy[0] = 1'b1;
        @(negedge clk);
        irdy[0] = 1'b0;
        check_eq("bp_release_vld", 128'(ovld[0]), 128'd0);
        for (int i = 0; i < 4; i++) begin
            if (busy[0] || ovld[0]) seen = 1'b1;
            @(negedge clk);
        end
        check_eq("bp_no_capture", 128'(seen), 128'd0);

        // Back-to-back with i_valid and i_ready held high
        irdy[0] = 1'b1; ivld[0] = 1'b1; iblk[0] = V1;
        #1;
        check_eq("b2b_idle_rdy", 128'(ordy[0]), 128'd1);
        @(negedge clk);
        iblk[0] = V2;
        t = 0; ta = -1; tb = -1;
        while (tb < 0 && t < 40) begin
            @(negedge clk); #1;
            t++;
            if (ta >= 0 && t == ta + 1) begin
                ivld[0] = 1'b0;
                check_eq("b2b_second_busy", 128'(busy[0]), 128'd1);
            end
            if (ovld[0]) begin
                if (ta < 0) begin
                    ta = t;
                    check_eq("b2b_first_blk", oblk[0], E1);
                    check_eq("b2b_first_rdy", 128'(ordy[0]), 128'd1);
                end else begin
                    tb = t;
                    check_eq("b2b_second_blk", oblk[0], E2);
                end
            end
        end
        check_eq("b2b_first_lat", 128'(ta), 128'd4);
        check_eq("b2b_period", 128'(tb - ta), 128'd5);
        @(negedge clk);
        irdy[0] = 1'b0;
        check_eq("b2b_drop", 128'(ovld[0]), 128'd0);

        // Reset in the second CALC cycle
        send(0, V2);
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check_eq("mid_rst_rdy_forced", 128'(ordy[0]), 128'd0);
        @(negedge clk);
        check_eq("mid_rst_vld", 128'(ovld[0]), 128'd0);
        check_eq("mid_rst_blk", oblk[0], 128'd0);
        check_eq("mid_rst_busy", 128'(busy[0]), 128'd0);
        rst[0] = 1'b0;
        #1;
        check_eq("mid_rst_rdy_after", 128'(ordy[0]), 128'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ovld[0]) seen = 1'b1;
        end
        check_eq("mid_rst_no_pulse", 128'(seen), 128'd0);
        send(0, V1);
        wait_result(0, E1, 4, "post_rst");

        // Random traffic with stalls at every width
        rand_run(0, 1000);
        rand_run(1, 200);
        rand_run(2, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
